// File: rtl/fft_power_pkg.sv
// Shared widths, lane word types, rounding/saturation helpers and the
// accumulator state encoding for the FFT power integrator.
package fft_power_pkg;

  localparam int PWR_IN_W    = 32;
  localparam int PWR_OUT_W   = 53;
  localparam int PWR_LSB_CUT = 10;
  localparam int PWR_LANES   = 4;
  localparam int PWR_SUM_W   = 2 * PWR_IN_W + 1;
  localparam int PWR_RND_W   = PWR_SUM_W - PWR_LSB_CUT + 1;

  localparam logic [PWR_SUM_W:0] PWR_RND_BIAS = (PWR_SUM_W + 1)'(1) << (PWR_LSB_CUT - 1);

  typedef logic signed [PWR_IN_W-1:0]                  in_word_t;
  typedef logic        [PWR_OUT_W-1:0]                 out_word_t;
  typedef logic signed [PWR_LANES-1:0][PWR_IN_W-1:0]  in_lane_vec_t;
  typedef logic        [PWR_LANES-1:0][PWR_OUT_W-1:0] out_lane_vec_t;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_t;

  // Round half-up after dropping LSB_CUT bits; returns {sat, value}.
  function automatic logic [PWR_OUT_W:0] round_sat(input logic [PWR_SUM_W-1:0] sum);
    logic [PWR_SUM_W:0]   biased;
    logic [PWR_RND_W-1:0] shifted;
    biased  = {1'b0, sum} + PWR_RND_BIAS;
    shifted = biased[PWR_SUM_W:PWR_LSB_CUT];
    if (|shifted[PWR_RND_W-1:PWR_OUT_W]) begin
      return {1'b1, {PWR_OUT_W{1'b1}}};
    end
    return {1'b0, shifted[PWR_OUT_W-1:0]};
  endfunction

  // Unsigned add clamped to all-ones; returns {sat, value}.
  function automatic logic [PWR_OUT_W:0] sat_add(input logic [PWR_OUT_W-1:0] a,
                                                 input logic [PWR_OUT_W-1:0] b);
    logic [PWR_OUT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[PWR_OUT_W]) begin
      return {1'b1, {PWR_OUT_W{1'b1}}};
    end
    return s;
  endfunction

endpackage

// File: rtl/fft_power_lane.sv
// Three-stage |X|^2 datapath for one complex sample: mask+square, sum,
// round with clamp. Frozen whenever en is low.
module fft_power_lane
  import fft_power_pkg::*;
#(
  parameter int IN_W  = PWR_IN_W,
  parameter int OUT_W = PWR_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             zero,
  input  logic [IN_W-1:0]  re,
  input  logic [IN_W-1:0]  im,
  output logic [OUT_W-1:0] pwr,
  output logic             sat
);

  logic signed [2*IN_W-1:0] re_ext;
  logic signed [2*IN_W-1:0] im_ext;
  logic signed [2*IN_W-1:0] sq_re_reg;
  logic signed [2*IN_W-1:0] sq_im_reg;
  logic        [2*IN_W:0]   sum_reg;
  logic        [OUT_W:0]    rnd;
  logic        [OUT_W-1:0]  pwr_reg;
  logic                     sat_reg;

  assign re_ext = {{IN_W{re[IN_W-1]}}, re};
  assign im_ext = {{IN_W{im[IN_W-1]}}, im};
  assign rnd    = round_sat(sum_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_re_reg <= '0;
      sq_im_reg <= '0;
      sum_reg   <= '0;
      pwr_reg   <= '0;
      sat_reg   <= 1'b0;
    end else if (en) begin
      sq_re_reg <= zero ? '0 : re_ext * re_ext;
      sq_im_reg <= zero ? '0 : im_ext * im_ext;
      // Squares are non-negative, so zero-extension keeps the sum exact.
      sum_reg   <= {1'b0, sq_re_reg} + {1'b0, sq_im_reg};
      pwr_reg   <= rnd[OUT_W-1:0];
      sat_reg   <= rnd[OUT_W];
    end
  end

  assign pwr = pwr_reg;
  assign sat = sat_reg;

endmodule

// File: rtl/fft_power_accum.sv
// Per-lane FFT power with optional integration over cfg_acc_len beats or
// until in_last, behind a valid/ready handshake that freezes on stall.
module fft_power_accum
  import fft_power_pkg::*;
#(
  parameter int            CH        = 2,
  parameter int            LANES     = 4,
  parameter int            IN_W      = PWR_IN_W,
  parameter int            OUT_W     = PWR_OUT_W,
  parameter int            IDX_W     = 11,
  parameter int            CNT_W     = 8,
  parameter int            ZERO_BINS = 2,
  parameter logic [CH-1:0] ZERO_MASK = 2'b10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [IDX_W-1:0]          in_index,
  input  logic [CH*LANES*IN_W-1:0]  in_re,
  input  logic [CH*LANES*IN_W-1:0]  in_im,
  input  logic [CNT_W-1:0]          cfg_acc_len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH*LANES*OUT_W-1:0] out_pwr,
  output logic [IDX_W-1:0]          out_index,
  output logic [CNT_W-1:0]          out_cnt,
  output logic                      out_sat
);

  localparam int NL = CH * LANES;
  localparam logic [IDX_W-1:0] ZB = IDX_W'(ZERO_BINS);

  logic                      stall;
  logic [CH-1:0]             zero_ch;
  logic [NL-1:0][OUT_W-1:0]  lane_pwr;
  logic [NL-1:0]             lane_sat;
  logic [NL-1:0][OUT_W-1:0]  add_sum;
  logic [NL-1:0]             add_ovf;

  logic                      v1_reg, v2_reg, v3_reg;
  logic                      last1_reg, last2_reg, last3_reg;
  logic [IDX_W-1:0]          idx1_reg, idx2_reg, idx3_reg;

  acc_state_t                state_reg, state_next;
  logic [NL-1:0][OUT_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [CNT_W-1:0]          len_reg, len_next;
  logic                      gsat_reg, gsat_next;
  logic                      done;

  logic                      out_valid_reg;
  logic [NL-1:0][OUT_W-1:0]  out_pwr_reg;
  logic [IDX_W-1:0]          out_index_reg;
  logic [CNT_W-1:0]          out_cnt_reg;
  logic                      out_sat_reg;

  assign stall    = out_valid_reg && !out_ready;
  assign in_ready = rst_n && !stall;

  for (genvar gi = 0; gi < CH; gi++) begin : g_zero
    assign zero_ch[gi] = ZERO_MASK[gi] && (in_index < ZB);
  end

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    fft_power_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!stall),
      .zero  (zero_ch[gi / LANES]),
      .re    (in_re[gi*IN_W +: IN_W]),
      .im    (in_im[gi*IN_W +: IN_W]),
      .pwr   (lane_pwr[gi]),
      .sat   (lane_sat[gi])
    );
    assign {add_ovf[gi], add_sum[gi]} = sat_add(acc_reg[gi], lane_pwr[gi]);
  end

  // Valid, index and last ride alongside the three lane stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
      last1_reg <= 1'b0;
      last2_reg <= 1'b0;
      last3_reg <= 1'b0;
      idx1_reg  <= '0;
      idx2_reg  <= '0;
      idx3_reg  <= '0;
    end else if (!stall) begin
      v1_reg    <= in_valid;
      v2_reg    <= v1_reg;
      v3_reg    <= v2_reg;
      last1_reg <= in_last;
      last2_reg <= last1_reg;
      last3_reg <= last2_reg;
      idx1_reg  <= in_index;
      idx2_reg  <= idx1_reg;
      idx3_reg  <= idx2_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    gsat_next  = gsat_reg;
    done       = 1'b0;
    if (v3_reg && !stall) begin
      if (state_reg == ACC_IDLE) begin
        len_next  = (cfg_acc_len == '0) ? CNT_W'(1) : cfg_acc_len;
        acc_next  = lane_pwr;
        cnt_next  = CNT_W'(1);
        gsat_next = |lane_sat;
      end else begin
        acc_next  = add_sum;
        cnt_next  = cnt_reg + CNT_W'(1);
        gsat_next = gsat_reg | (|lane_sat) | (|add_ovf);
      end
      done       = (cnt_next == len_next) || last3_reg;
      state_next = done ? ACC_IDLE : ACC_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACC_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      gsat_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pwr_reg   <= '0;
      out_index_reg <= '0;
      out_cnt_reg   <= '0;
      out_sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      gsat_reg  <= gsat_next;
      // A completing group wins over a same-cycle consume.
      if (done) begin
        out_valid_reg <= 1'b1;
        out_pwr_reg   <= acc_next;
        out_index_reg <= idx3_reg;
        out_cnt_reg   <= cnt_next;
        out_sat_reg   <= gsat_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_pwr   = out_pwr_reg;
  assign out_index = out_index_reg;
  assign out_cnt   = out_cnt_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_fft_power_accum.sv
// Directed bench for fft_power_accum: table of single-beat vectors plus
// hand sequences for integration, last, bubbles, backpressure and reset.
module tb_fft_power_accum;

  localparam int CH    = 2;
  localparam int LANES = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 53;
  localparam int IDX_W = 11;
  localparam int CNT_W = 8;
  localparam int NL    = CH * LANES;
  localparam int PW    = NL * OUT_W;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_last = 1'b0;
  logic [IDX_W-1:0]     in_index = '0;
  logic [NL*IN_W-1:0]   in_re = '0;
  logic [NL*IN_W-1:0]   in_im = '0;
  logic [CNT_W-1:0]     cfg_acc_len = 8'd1;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [PW-1:0]        out_pwr;
  logic [IDX_W-1:0]     out_index;
  logic [CNT_W-1:0]     out_cnt;
  logic                 out_sat;

  int checks = 0;
  int errors = 0;

  fft_power_accum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_index    (in_index),
    .in_re       (in_re),
    .in_im       (in_im),
    .cfg_acc_len (cfg_acc_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pwr     (out_pwr),
    .out_index   (out_index),
    .out_cnt     (out_cnt),
    .out_sat     (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      re;
    logic [31:0]      im;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] len;
    logic [OUT_W-1:0] e0;
    logic [OUT_W-1:0] e1;
    logic             esat;
  } vec_t;

  vec_t vecs[12];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkexp(input logic [OUT_W-1:0] e0, input logic [OUT_W-1:0] e1);
    logic [PW-1:0] v;
    v = '0;
    for (int n = 0; n < NL; n++) v[n*OUT_W +: OUT_W] = (n < LANES) ? e0 : e1;
    return v;
  endfunction

  task automatic fill(input logic [31:0] re, input logic [31:0] im);
    for (int n = 0; n < NL; n++) begin
      in_re[n*IN_W +: IN_W] = re;
      in_im[n*IN_W +: IN_W] = im;
    end
  endtask

  task automatic send_beat(input logic [IDX_W-1:0] idx, input logic last);
    int g;
    g = 0;
    in_index = idx;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      step;
      g++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_beat: in_ready got 0 expected 1");
    end
    step;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_out: out_valid got 0 after %0d cycles expected 1", lat);
    end
  endtask

  task automatic check_out(input string name, input logic [PW-1:0] e_pwr, input logic [IDX_W-1:0] e_idx,
                           input logic [CNT_W-1:0] e_cnt, input logic e_sat);
    $display("txn %s: index=%0d cnt=%0d sat=%0d lane0=%0d", name, out_index, out_cnt, out_sat,
             out_pwr[OUT_W-1:0]);
    chk({name, "_pwr"}, out_pwr, e_pwr);
    chk({name, "_index"}, PW'(out_index), PW'(e_idx));
    chk({name, "_cnt"}, PW'(out_cnt), PW'(e_cnt));
    chk({name, "_sat"}, PW'(out_sat), PW'(e_sat));
  endtask

  initial begin
    int lat;
    int extra;
    int tx;
    int rx;
    int stall_cycles;
    logic [PW-1:0] held_pwr;
    logic [PW-1:0] e;
    logic [OUT_W-1:0] ones;
    logic [OUT_W-1:0] half;

    ones = '1;
    half = OUT_W'(1) << 52;
    vecs[0]  = '{32'd1024,     32'd0,          11'd5,    8'd1, 53'd1024, 53'd1024, 1'b0};
    vecs[1]  = '{32'd16,       32'd16,         11'd5,    8'd1, 53'd1,    53'd1,    1'b0};
    vecs[2]  = '{32'd15,       32'd15,         11'd5,    8'd1, 53'd0,    53'd0,    1'b0};
    vecs[3]  = '{32'h80000000, 32'h80000000,   11'd5,    8'd1, ones,     ones,     1'b1};
    vecs[4]  = '{32'd1024,     32'd0,          11'd1,    8'd1, 53'd1024, 53'd0,    1'b0};
    vecs[5]  = '{32'd1024,     32'd0,          11'd2,    8'd1, 53'd1024, 53'd1024, 1'b0};
    vecs[6]  = '{32'h80000000, 32'd0,          11'd0,    8'd1, half,     53'd0,    1'b0};
    vecs[7]  = '{32'd0,        32'hFFFFFC00,   11'd7,    8'd0, 53'd1024, 53'd1024, 1'b0};
    vecs[8]  = '{32'd1000,     32'd1000,       11'd9,    8'd1, 53'd1953, 53'd1953, 1'b0};
    vecs[9]  = '{32'd23,       32'd0,          11'd3,    8'd1, 53'd1,    53'd1,    1'b0};
    vecs[10] = '{32'd22,       32'd0,          11'd3,    8'd1, 53'd0,    53'd0,    1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF,   11'd2047, 8'd1, 53'd0,    53'd0,    1'b0};

    // Reset state
    step;
    step;
    chk("rst_in_ready", PW'(in_ready), PW'(0));
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", PW'(in_ready), PW'(1));
    chk("post_rst_out_valid", PW'(out_valid), PW'(0));

    // Single-beat table
    for (int i = 0; i < 12; i++) begin
      cfg_acc_len = vecs[i].len;
      fill(vecs[i].re, vecs[i].im);
      send_beat(vecs[i].idx, 1'b0);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), PW'(lat), PW'(4));
      check_out($sformatf("vec%0d", i), mkexp(vecs[i].e0, vecs[i].e1), vecs[i].idx, 8'd1, vecs[i].esat);
      step;
      chk($sformatf("vec%0d_consumed", i), PW'(out_valid), PW'(0));
    end

    // Distinct per-lane values check the [CH][LANES] packing
    cfg_acc_len = 8'd1;
    for (int n = 0; n < NL; n++) begin
      in_re[n*IN_W +: IN_W] = 32'(32 * (n + 1));
      in_im[n*IN_W +: IN_W] = 32'd0;
    end
    e = '0;
    for (int n = 0; n < NL; n++) e[n*OUT_W +: OUT_W] = OUT_W'((n + 1) * (n + 1));
    send_beat(11'd5, 1'b0);
    wait_out(lat);
    check_out("lane_ramp", e, 11'd5, 8'd1, 1'b0);
    step;

    // Integration over four back-to-back beats
    cfg_acc_len = 8'd4;
    fill(32'd1024, 32'd0);
    for (int k = 0; k < 4; k++) send_beat(IDX_W'(20 + k), 1'b0);
    wait_out(lat);
    chk("int4_latency", PW'(lat), PW'(4));
    check_out("int4", mkexp(53'd4096, 53'd4096), 11'd23, 8'd4, 1'b0);
    step;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) extra++;
      step;
    end
    chk("int4_single_result", PW'(extra), PW'(0));

    // Bubbles between beats do not advance the count
    cfg_acc_len = 8'd3;
    fill(32'd1024, 32'd0);
    send_beat(11'd50, 1'b0);
    step;
    step;
    fill(32'd32, 32'd0);
    send_beat(11'd51, 1'b0);
    step;
    fill(32'd1024, 32'd0);
    send_beat(11'd52, 1'b0);
    wait_out(lat);
    check_out("bubble3", mkexp(53'd2049, 53'd2049), 11'd52, 8'd3, 1'b0);
    step;

    // in_last closes the group early; next group starts clean
    cfg_acc_len = 8'd4;
    fill(32'd1024, 32'd0);
    send_beat(11'd30, 1'b0);
    send_beat(11'd31, 1'b1);
    wait_out(lat);
    check_out("last2", mkexp(53'd2048, 53'd2048), 11'd31, 8'd2, 1'b0);
    step;
    cfg_acc_len = 8'd1;
    send_beat(11'd32, 1'b0);
    wait_out(lat);
    check_out("after_last", mkexp(53'd1024, 53'd1024), 11'd32, 8'd1, 1'b0);
    step;

    // Length latched at group start; a later cfg change is ignored
    cfg_acc_len = 8'd2;
    send_beat(11'd60, 1'b0);
    repeat (4) step;
    cfg_acc_len = 8'd1;
    send_beat(11'd61, 1'b0);
    wait_out(lat);
    check_out("cfg_midgroup", mkexp(53'd2048, 53'd2048), 11'd61, 8'd2, 1'b0);
    step;

    // Accumulator saturation: 2^52 + 2^52 overflows 53 bits
    cfg_acc_len = 8'd2;
    fill(32'h80000000, 32'd0);
    send_beat(11'd9, 1'b0);
    send_beat(11'd10, 1'b0);
    wait_out(lat);
    check_out("acc_sat", mkexp(ones, ones), 11'd10, 8'd2, 1'b1);
    step;

    // Backpressure: 10 beats, out_ready low for 3 cycles
    cfg_acc_len = 8'd1;
    tx = 0;
    rx = 0;
    stall_cycles = 0;
    held_pwr = '0;
    for (int cyc = 0; cyc < 200 && rx < 10; cyc++) begin
      step;
      out_ready = !(cyc >= 8 && cyc < 11);
      in_valid  = (tx < 10);
      fill(32'(32 * (tx + 1)), 32'd0);
      in_index  = IDX_W'(40 + tx);
      #1;
      if (!out_ready && out_valid) begin
        stall_cycles++;
        chk("bp_in_ready_low", PW'(in_ready), PW'(0));
        if (stall_cycles > 1) chk("bp_hold", out_pwr, held_pwr);
        held_pwr = out_pwr;
      end
      if (out_valid && out_ready) begin
        check_out($sformatf("bp%0d", rx), mkexp(OUT_W'((rx + 1) * (rx + 1)), OUT_W'((rx + 1) * (rx + 1))),
                  IDX_W'(40 + rx), 8'd1, 1'b0);
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_received", PW'(rx), PW'(10));
    chk("bp_stall_cycles", PW'(stall_cycles), PW'(3));
    step;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) extra++;
      step;
    end
    chk("bp_no_duplicate", PW'(extra), PW'(0));

    // Asynchronous reset with a result held under stall
    cfg_acc_len = 8'd1;
    out_ready = 1'b0;
    fill(32'd1024, 32'd0);
    send_beat(11'd77, 1'b0);
    wait_out(lat);
    step;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", PW'(out_valid), PW'(0));
    chk("arst_out_pwr", out_pwr, PW'(0));
    chk("arst_out_index", PW'(out_index), PW'(0));
    chk("arst_out_cnt", PW'(out_cnt), PW'(0));
    chk("arst_out_sat", PW'(out_sat), PW'(0));
    chk("arst_in_ready", PW'(in_ready), PW'(0));
    step;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("arst_release_in_ready", PW'(in_ready), PW'(1));
    chk("arst_release_out_valid", PW'(out_valid), PW'(0));

    // Reset mid-group discards the partial sum
    cfg_acc_len = 8'd4;
    fill(32'd1024, 32'd0);
    send_beat(11'd80, 1'b0);
    send_beat(11'd81, 1'b0);
    repeat (5) step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    #1;
    fill(32'd32, 32'd0);
    for (int k = 0; k < 4; k++) send_beat(IDX_W'(90 + k), 1'b0);
    wait_out(lat);
    check_out("rst_discard", mkexp(53'd4, 53'd4), 11'd93, 8'd4, 1'b0);
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_power_accum.md
Name: fft_power_accum

Overview:
- Parametrised successor to the single-shot FFT power stage.
- Computes per-lane |X|^2 = re^2 + im^2 for CH channels x LANES lanes per beat, then rounds and saturates.
- Optionally integrates (sums) power over a run-time number of consecutive beats or up to a frame-last marker.
- Sits between the FFT output reorder and the spectrum/detector logic; adds valid/ready backpressure.

Parameters:
- CH, 2, number of independent channels (columns).
- LANES, 4, samples per channel per beat.
- IN_W, 32, signed input width of re/im.
- OUT_W, 53, unsigned output/accumulator width.
- LSB_CUT, 10, LSBs dropped by rounding after the re^2+im^2 sum.
- IDX_W, 11, bin-index width.
- CNT_W, 8, width of the accumulation-length config and output beat count.
- ZERO_BINS, 2, indices below this are forced to zero on masked channels.
- ZERO_MASK, 'b10, per-channel bit; 1 = channel zeroed when in_index < ZERO_BINS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_last  in  1  beat closes the current accumulation group early
- in_index  in  IDX_W  bin index of the beat
- in_re  in  CH*LANES*IN_W  signed real parts, packed [CH][LANES]
- in_im  in  CH*LANES*IN_W  signed imaginary parts, same packing
- cfg_acc_len  in  CNT_W  beats per group; 0 treated as 1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_pwr  out  CH*LANES*OUT_W  integrated power, packed [CH][LANES]
- out_index  out  IDX_W  index of the last beat in the group
- out_cnt  out  CNT_W  beats summed into this result
- out_sat  out  1  any saturation (rounding clamp or accumulate) in this group

Behaviour:
- Reset: all pipeline registers, valid bits, accumulators, counter, out_valid, out_pwr, out_index, out_cnt and out_sat go to 0; in_ready = 0 during reset, 1 after.
- Handshake: beat accepted when in_valid && in_ready. Result consumed when out_valid && out_ready.
- stall = out_valid && !out_ready. in_ready = !stall. The whole pipeline freezes while stalled; outputs hold stable.
- Pipeline (per stage valid bit; index, last and sat flags travel with data):
  - S1: mask channels per ZERO_MASK/ZERO_BINS, register signed squares (2*IN_W bits).
  - S2: register unsigned sum (2*IN_W+1 bits).
  - S3: drop LSB_CUT bits with round-half-up (add bit LSB_CUT-1). If the result exceeds OUT_W bits, clamp to all-ones and set the sat flag.
  - S4: accumulate and emit.
- Latency: with cfg_acc_len <= 1, out_valid rises 4 clk after the accept edge (accept edge = edge 1).
- Accumulator FSM, states ACC_IDLE and ACC_RUN:
  - ACC_IDLE + S3 beat: latch len = max(cfg_acc_len,1); acc = p; cnt = 1.
  - ACC_RUN + S3 beat: acc = sat(acc + p); cnt++.
  - Group completes when cnt reaches len or the beat carries last. Then load out_* and set out_valid. Next state is ACC_IDLE.
  - Otherwise the next state is ACC_RUN.
  - cfg_acc_len changes mid-group have no effect until the next group.
- Accumulate saturation: sum > 2^OUT_W-1 gives all-ones and sets sat. sat is the OR over the whole group.
- out_valid clears on consume unless a new group completes in the same cycle, in which case new data loads.
- Non-valid cycles (bubbles) do not advance cnt.
- Reset mid-group discards the partial accumulation.

Decomposition:
- Package fft_power_pkg holds:
  - packed typedefs for lane vectors of IN_W and OUT_W;
  - function round_sat(sum) returning {sat, value};
  - function sat_add(a, b);
  - the accumulator state enum.
- One sub-module, fft_power_lane: S1..S3 for a single complex sample. It has a stall enable and an sat output. Instantiate it CH*LANES times via generate. The top level owns the valid pipeline, FSM and counter.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-traffic -> all outputs 0 immediately.
  - After release, in_ready=1, out_valid=0.
- Single beat:
  - Stimulus: acc_len=1, all re=1024, im=0, index=5.
  - Response: 4 clk later out_pwr lanes = 1024, out_index=5, out_cnt=1, out_sat=0.
- Rounding/saturation:
  - re=im=16 (sum 512) -> 1 (round up).
  - re=im=15 (450) -> 0.
  - re=im=-2^31 -> all-ones (2^53-1), out_sat=1.
- Integration:
  - acc_len=4, four beats of re=1024 -> one result of 4096, out_cnt=4, index of the 4th beat.
  - acc_len=4 with in_last on the 2nd beat -> 2048, out_cnt=2.
- Backpressure:
  - Stream 10 beats with acc_len=1; hold out_ready=0 for 3 cycles.
  - Response: in_ready=0 those cycles, out_pwr stable, all 10 results delivered in order, none lost or duplicated.
- Zero bins:
  - Stimulus: index=1, re=1024 on both channels.
  - Response: ch0 = 1024, ch1 = 0. At index=2, both channels = 1024.
